// File: rtl/rv32_pkg.sv
// -----------------------------------------------------------------------------
// rv32_pkg
// Shared types and constants for the RV32 core sequencer slice.
//   seq_state_e  : sequencer FSM states
//   trap_cause_e : encoding of the trap_cause output
//   OPC_*        : RV32I major opcodes (instr[6:0])
//   INSTR_NOP    : canonical NOP (addi x0, x0, 0), reset value of ir
//   FMT_*        : bit positions in the decoder's one-hot {r,i,s,b,u,j} vector
// -----------------------------------------------------------------------------
package rv32_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_TRAP      = 3'd6
    } seq_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_BUS_ERR = 2'd1,
        CAUSE_TIMEOUT = 2'd2,
        CAUSE_ILLEGAL = 2'd3
    } trap_cause_e;

    localparam logic [6:0] OPC_LOAD     = 7'b000_0011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b000_1111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b001_0011;
    localparam logic [6:0] OPC_AUIPC    = 7'b001_0111;
    localparam logic [6:0] OPC_STORE    = 7'b010_0011;
    localparam logic [6:0] OPC_OP       = 7'b011_0011;
    localparam logic [6:0] OPC_LUI      = 7'b011_0111;
    localparam logic [6:0] OPC_BRANCH   = 7'b110_0011;
    localparam logic [6:0] OPC_JALR     = 7'b110_0111;
    localparam logic [6:0] OPC_JAL      = 7'b110_1111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b111_0011;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    // Bit positions inside dec_instruction_format = {r,i,s,b,u,j}
    localparam int unsigned FMT_R = 5;
    localparam int unsigned FMT_I = 4;
    localparam int unsigned FMT_S = 3;
    localparam int unsigned FMT_B = 2;
    localparam int unsigned FMT_U = 1;
    localparam int unsigned FMT_J = 0;

    // Only r/i/u/j formats carry an rd; stores and branches never write back.
    function automatic logic fmt_writes_rd(input logic [5:0] fmt);
        return fmt[FMT_R] | fmt[FMT_I] | fmt[FMT_U] | fmt[FMT_J];
    endfunction

    // Instruction addresses must be word aligned (no compressed support).
    function automatic logic addr_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/rv32_mod_bus_timeout.sv
// -----------------------------------------------------------------------------
// rv32_mod_bus_timeout
// Counts consecutive bus request cycles that receive neither ack nor err and
// flags the cycle in which the limit is reached.
//   clk, rstn : clock, async active-low reset
//   clear     : hold the counter at zero (no request outstanding)
//   active    : a request is being presented this cycle
//   done      : ack or err seen this cycle (completion beats expiry)
//   expired   : this is the BUS_TIMEOUT-th silent request cycle
// BUS_TIMEOUT = 0 disables expiry entirely.
// -----------------------------------------------------------------------------
module rv32_mod_bus_timeout #(
    parameter int unsigned BUS_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic active,
    input  logic done,
    output logic expired
);

    localparam int unsigned CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    // Count value present during the last permitted silent cycle.
    localparam logic [CNT_W-1:0] LAST_CNT =
        (BUS_TIMEOUT > 0) ? CNT_W'(BUS_TIMEOUT - 1) : {CNT_W{1'b0}};
    localparam logic TIMEOUT_EN = (BUS_TIMEOUT != 0);

    logic [CNT_W-1:0] wait_cnt_r;

    // Wait counter: cleared outside a request, advances on silent request cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (active && !done && (wait_cnt_r != LAST_CNT)) begin
            wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Expiry only when nothing completed in the limit cycle.
    always_comb begin
        expired = 1'b0;
        if (TIMEOUT_EN && active && !done && (wait_cnt_r == LAST_CNT)) begin
            expired = 1'b1;
        end else begin
            expired = 1'b0;
        end
    end

endmodule

// File: rtl/rv32_mod_core_sequencer.sv
// -----------------------------------------------------------------------------
// rv32_mod_core_sequencer
// Multi-cycle RV32 control sequencer: IDLE -> FETCH -> DECODE -> EXECUTE ->
// [MEM] -> WRITEBACK -> FETCH, with a terminal TRAP state on bus error,
// bus timeout, illegal instruction or misaligned branch target.
//   clk, rstn              : clock, async active-low reset
//   instr_req/addr         : fetch request, address (= pc)
//   instr_ack/err/rdata    : fetch response
//   ir                     : instruction register, feeds the external decoder
//   dec_*                  : decoder results for the word in ir
//   data_req/ack/err       : load/store handshake
//   branch_taken/target    : pc redirect, used in WRITEBACK
//   rf_write_en            : register-file write strobe
//   pc                     : program counter
//   trap, trap_cause       : halted flag and reason
// All outputs are registered and decoded from the state being entered.
// -----------------------------------------------------------------------------
module rv32_mod_core_sequencer
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        instr_req,
    output logic [31:0] instr_addr,
    input  logic        instr_ack,
    input  logic        instr_err,
    input  logic [31:0] instr_rdata,
    output logic [31:0] ir,
    input  logic        dec_is_compressed,
    input  logic        dec_is_mem_or_io,
    input  logic [5:0]  dec_instruction_format,
    output logic        data_req,
    input  logic        data_ack,
    input  logic        data_err,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        rf_write_en,
    output logic [31:0] pc,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    seq_state_e  state_r;
    seq_state_e  next_state_s;
    trap_cause_e trap_cause_r;
    trap_cause_e next_cause_s;
    logic [31:0] pc_r;
    logic [31:0] next_pc_s;
    logic [31:0] ir_r;
    logic        ir_load_s;
    logic        instr_req_r;
    logic        data_req_r;
    logic        trap_r;
    logic        rf_write_en_r;

    logic        req_active_s;
    logic        bus_ack_s;
    logic        bus_err_s;
    logic        bus_done_s;
    logic        bus_expired_s;
    logic        timeout_clear_s;

    // Select the handshake of whichever bus is being requested; responses on
    // an idle bus never reach the FSM.
    always_comb begin
        req_active_s = 1'b0;
        bus_ack_s    = 1'b0;
        bus_err_s    = 1'b0;
        case (state_r)
            ST_FETCH: begin
                req_active_s = 1'b1;
                bus_ack_s    = instr_ack;
                bus_err_s    = instr_err;
            end
            ST_MEM: begin
                req_active_s = 1'b1;
                bus_ack_s    = data_ack;
                bus_err_s    = data_err;
            end
            default: begin
                req_active_s = 1'b0;
                bus_ack_s    = 1'b0;
                bus_err_s    = 1'b0;
            end
        endcase
    end

    assign bus_done_s      = bus_ack_s | bus_err_s;
    // FETCH and MEM are never entered back-to-back, so holding the counter at
    // zero outside them is the same as clearing it on entry.
    assign timeout_clear_s = ~req_active_s;

    rv32_mod_bus_timeout #(
        .BUS_TIMEOUT (BUS_TIMEOUT)
    ) u_bus_timeout (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (timeout_clear_s),
        .active  (req_active_s),
        .done    (bus_done_s),
        .expired (bus_expired_s)
    );

    // Next-state, next-pc and trap-cause selection.
    always_comb begin
        next_state_s = state_r;
        next_cause_s = trap_cause_r;
        next_pc_s    = pc_r;
        ir_load_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                next_state_s = ST_FETCH;
            end
            ST_FETCH: begin
                // err outranks ack; ack outranks timeout expiry
                if (bus_err_s) begin
                    next_state_s = ST_TRAP;
                    next_cause_s = CAUSE_BUS_ERR;
                end else if (bus_ack_s) begin
                    next_state_s = ST_DECODE;
                    ir_load_s    = 1'b1;
                end else if (bus_expired_s) begin
                    next_state_s = ST_TRAP;
                    next_cause_s = CAUSE_TIMEOUT;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (dec_is_compressed || (dec_instruction_format == 6'b00_0000)) begin
                    next_state_s = ST_TRAP;
                    next_cause_s = CAUSE_ILLEGAL;
                end else begin
                    next_state_s = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (dec_is_mem_or_io) begin
                    next_state_s = ST_MEM;
                end else begin
                    next_state_s = ST_WRITEBACK;
                end
            end
            ST_MEM: begin
                if (bus_err_s) begin
                    next_state_s = ST_TRAP;
                    next_cause_s = CAUSE_BUS_ERR;
                end else if (bus_ack_s) begin
                    next_state_s = ST_WRITEBACK;
                end else if (bus_expired_s) begin
                    next_state_s = ST_TRAP;
                    next_cause_s = CAUSE_TIMEOUT;
                end else begin
                    next_state_s = ST_MEM;
                end
            end
            ST_WRITEBACK: begin
                if (branch_taken) begin
                    if (addr_misaligned(branch_target)) begin
                        // pc stays on the offending branch
                        next_state_s = ST_TRAP;
                        next_cause_s = CAUSE_ILLEGAL;
                    end else begin
                        next_state_s = ST_FETCH;
                        next_pc_s    = branch_target;
                    end
                end else begin
                    next_state_s = ST_FETCH;
                    next_pc_s    = pc_r + 32'd4;
                end
            end
            ST_TRAP: begin
                next_state_s = ST_TRAP;
            end
            default: begin
                // Unreachable encoding: halt rather than run on corrupt state.
                next_state_s = ST_TRAP;
                next_cause_s = CAUSE_ILLEGAL;
            end
        endcase
    end

    // Sequencer state plus outputs registered from the state being entered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r       <= ST_IDLE;
            trap_cause_r  <= CAUSE_NONE;
            pc_r          <= RESET_PC;
            ir_r          <= INSTR_NOP;
            instr_req_r   <= 1'b0;
            data_req_r    <= 1'b0;
            trap_r        <= 1'b0;
            rf_write_en_r <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            trap_cause_r  <= next_cause_s;
            pc_r          <= next_pc_s;
            if (ir_load_s) begin
                ir_r <= instr_rdata;
            end else begin
                ir_r <= ir_r;
            end
            instr_req_r   <= (next_state_s == ST_FETCH);
            data_req_r    <= (next_state_s == ST_MEM);
            trap_r        <= (next_state_s == ST_TRAP);
            rf_write_en_r <= (next_state_s == ST_WRITEBACK) &&
                             fmt_writes_rd(dec_instruction_format);
        end
    end

    assign instr_req   = instr_req_r;
    assign instr_addr  = pc_r;
    assign pc          = pc_r;
    assign ir          = ir_r;
    assign data_req    = data_req_r;
    assign trap        = trap_r;
    assign trap_cause  = trap_cause_r;
    assign rf_write_en = rf_write_en_r;

endmodule

// File: tb/tb_rv32_mod_core_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rv32_mod_core_sequencer
// Directed, table-driven bench for rv32_mod_core_sequencer (RESET_PC=0x100,
// BUS_TIMEOUT=4). A tiny behavioural decoder derives the dec_* inputs from ir.
// Inputs change on the falling edge; outputs are compared on the falling edge
// after the rising edge that consumed them.
// -----------------------------------------------------------------------------
module tb_rv32_mod_core_sequencer;

    localparam logic [31:0] I_ADDI = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] I_LW   = 32'h0000_A103; // lw   x2,0(x1)
    localparam logic [31:0] I_SW   = 32'h0020_A023; // sw   x2,0(x1)
    localparam logic [31:0] I_ADD  = 32'h0020_81B3; // add  x3,x1,x2
    localparam logic [31:0] I_BEQ  = 32'h0000_0063; // beq  x0,x0,0
    localparam logic [31:0] I_CMP  = 32'h0000_0001; // compressed encoding

    logic        clk;
    logic        rstn;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_ack;
    logic        instr_err;
    logic [31:0] instr_rdata;
    logic [31:0] ir;
    logic        dec_is_compressed;
    logic        dec_is_mem_or_io;
    logic [5:0]  dec_instruction_format;
    logic        data_req;
    logic        data_ack;
    logic        data_err;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        rf_write_en;
    logic [31:0] pc;
    logic        trap;
    logic [1:0]  trap_cause;

    int n_checks = 0;
    int n_fail   = 0;

    rv32_mod_core_sequencer #(
        .RESET_PC    (32'h0000_0100),
        .BUS_TIMEOUT (4)
    ) dut (
        .clk                    (clk),
        .rstn                   (rstn),
        .instr_req              (instr_req),
        .instr_addr             (instr_addr),
        .instr_ack              (instr_ack),
        .instr_err              (instr_err),
        .instr_rdata            (instr_rdata),
        .ir                     (ir),
        .dec_is_compressed      (dec_is_compressed),
        .dec_is_mem_or_io       (dec_is_mem_or_io),
        .dec_instruction_format (dec_instruction_format),
        .data_req               (data_req),
        .data_ack               (data_ack),
        .data_err               (data_err),
        .branch_taken           (branch_taken),
        .branch_target          (branch_target),
        .rf_write_en            (rf_write_en),
        .pc                     (pc),
        .trap                   (trap),
        .trap_cause             (trap_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RV32 decoder for the word held in ir.
    always_comb begin
        dec_is_compressed      = (ir[1:0] != 2'b11);
        dec_is_mem_or_io       = 1'b0;
        dec_instruction_format = 6'b00_0000;
        case (ir[6:0])
            7'b011_0011: dec_instruction_format = 6'b10_0000;
            7'b001_0011,
            7'b110_0111: dec_instruction_format = 6'b01_0000;
            7'b000_0011: begin
                dec_instruction_format = 6'b01_0000;
                dec_is_mem_or_io       = 1'b1;
            end
            7'b010_0011: begin
                dec_instruction_format = 6'b00_1000;
                dec_is_mem_or_io       = 1'b1;
            end
            7'b110_0011: dec_instruction_format = 6'b00_0100;
            7'b011_0111,
            7'b001_0111: dec_instruction_format = 6'b00_0010;
            7'b110_1111: dec_instruction_format = 6'b00_0001;
            default:     dec_instruction_format = 6'b00_0000;
        endcase
    end

    typedef struct {
        logic        ia;
        logic        ie;
        logic [31:0] rd;
        logic        da;
        logic        de;
        logic        bt;
        logic [31:0] tg;
        logic        e_ireq;
        logic [31:0] e_addr;
        logic        e_dreq;
        logic        e_rf;
        logic        e_trap;
        logic [1:0]  e_cause;
    } vec_t;

    vec_t vq[$];

    task automatic vec(input logic ia, input logic ie, input logic [31:0] rd,
                       input logic da, input logic de, input logic bt,
                       input logic [31:0] tg, input logic e_ireq,
                       input logic [31:0] e_addr, input logic e_dreq,
                       input logic e_rf, input logic e_trap,
                       input logic [1:0] e_cause);
        vec_t v;
        v.ia = ia; v.ie = ie; v.rd = rd; v.da = da; v.de = de; v.bt = bt; v.tg = tg;
        v.e_ireq = e_ireq; v.e_addr = e_addr; v.e_dreq = e_dreq;
        v.e_rf = e_rf; v.e_trap = e_trap; v.e_cause = e_cause;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ia, input logic ie, input logic [31:0] rd,
                         input logic da, input logic de, input logic bt,
                         input logic [31:0] tg);
        instr_ack = ia; instr_err = ie; instr_rdata = rd;
        data_ack = da; data_err = de; branch_taken = bt; branch_target = tg;
    endtask

    // Apply inputs for one cycle, return on the following falling edge.
    task automatic cyc(input logic ia, input logic ie, input logic [31:0] rd,
                       input logic da, input logic de, input logic bt,
                       input logic [31:0] tg);
        drive(ia, ie, rd, da, de, bt, tg);
        @(negedge clk);
    endtask

    // Hold reset for two cycles, release on a falling edge.
    task automatic do_reset();
        rstn = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst.instr_req",  {31'd0, instr_req},   32'd0);
        chk("rst.instr_addr", instr_addr,           32'h0000_0100);
        chk("rst.pc",         pc,                   32'h0000_0100);
        chk("rst.ir",         ir,                   32'h0000_0013);
        chk("rst.data_req",   {31'd0, data_req},    32'd0);
        chk("rst.rf_we",      {31'd0, rf_write_en}, 32'd0);
        chk("rst.trap",       {31'd0, trap},        32'd0);
        chk("rst.cause",      {30'd0, trap_cause},  32'd0);

        // ---- main program table -------------------------------------------
        //   ia   ie   rdata  da   de   bt   target        ireq addr           dreq rf   trap cause
        vec(1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,         1'b1,32'h0000_0100,1'b0,1'b0,1'b0,2'd0); // IDLE->FETCH
        vec(1'b1,1'b0,I_ADDI,1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0000_0100,1'b0,1'b0,1'b0,2'd0); // DECODE
        vec(1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0000_0100,1'b0,1'b0,1'b0,2'd0); // EXECUTE
        vec(1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0000_0100,1'b0,1'b1,1'b0,2'd0); // WB, 4th cycle
        vec(1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,         1'b1,32'h0000_0104,1'b0,1'b0,1'b0,2'd0); // FETCH 0x104
        vec(1'b1,1'b0,I_LW,  1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0000_0104,1'b0,1'b0,1'b0,2'd0); // DECODE
        vec(1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0000_0104,1'b0,1'b0,1'b0,2'd0); // EXECUTE
        vec(1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0000_0104,1'b1,1'b0,1'b0,2'd0); // MEM 1
        vec(1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0000_0104,1'b1,1'b0,1'b0,2'd0); // MEM 2
        vec(1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0000_0104,1'b1,1'b0,1'b0,2'd0); // MEM 3
        vec(1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0000_0104,1'b1,1'b0,1'b0,2'd0); // MEM 4
        vec(1'b0,1'b0,32'h0, 1'b1,1'b0,1'b0,32'h0,         1'b0,32'h0000_0104,1'b0,1'b1,1'b0,2'd0); // ack in 4th: WB
        vec(1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,         1'b1,32'h0000_0108,1'b0,1'b0,1'b0,2'd0); // FETCH 0x108
        vec(1'b1,1'b0,I_BEQ, 1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0000_0108,1'b0,1'b0,1'b0,2'd0); // DECODE
        vec(1'b0,1'b0,32'h0, 1'b1,1'b0,1'b0,32'h0,         1'b0,32'h0000_0108,1'b0,1'b0,1'b0,2'd0); // stray data_ack
        vec(1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0000_0108,1'b0,1'b0,1'b0,2'd0); // WB, no rf write
        vec(1'b0,1'b0,32'h0, 1'b0,1'b0,1'b1,32'h0000_0200, 1'b1,32'h0000_0200,1'b0,1'b0,1'b0,2'd0); // taken -> 0x200
        vec(1'b1,1'b0,I_ADD, 1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0000_0200,1'b0,1'b0,1'b0,2'd0);
        vec(1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0000_0200,1'b0,1'b0,1'b0,2'd0);
        vec(1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0000_0200,1'b0,1'b1,1'b0,2'd0); // r-type writes
        vec(1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,         1'b1,32'h0000_0204,1'b0,1'b0,1'b0,2'd0);
        vec(1'b1,1'b0,I_SW,  1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0000_0204,1'b0,1'b0,1'b0,2'd0);
        vec(1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0000_0204,1'b0,1'b0,1'b0,2'd0);
        vec(1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0000_0204,1'b1,1'b0,1'b0,2'd0); // MEM
        vec(1'b0,1'b0,32'h0, 1'b1,1'b0,1'b0,32'h0,         1'b0,32'h0000_0204,1'b0,1'b0,1'b0,2'd0); // WB, store: no rf
        vec(1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,         1'b1,32'h0000_0208,1'b0,1'b0,1'b0,2'd0);
        vec(1'b1,1'b0,I_BEQ, 1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0000_0208,1'b0,1'b0,1'b0,2'd0);
        vec(1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0000_0208,1'b0,1'b0,1'b0,2'd0);
        vec(1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0000_0208,1'b0,1'b0,1'b0,2'd0);
        vec(1'b0,1'b0,32'h0, 1'b0,1'b0,1'b1,32'h0000_0202, 1'b0,32'h0000_0208,1'b0,1'b0,1'b1,2'd3); // misaligned
        vec(1'b1,1'b0,I_ADD, 1'b1,1'b0,1'b1,32'h0000_0300, 1'b0,32'h0000_0208,1'b0,1'b0,1'b1,2'd3); // terminal
        vec(1'b0,1'b1,32'h0, 1'b0,1'b1,1'b0,32'h0,         1'b0,32'h0000_0208,1'b0,1'b0,1'b1,2'd3);

        do_reset();
        for (int i = 0; i < vq.size(); i++) begin
            cyc(vq[i].ia, vq[i].ie, vq[i].rd, vq[i].da, vq[i].de, vq[i].bt, vq[i].tg);
            chk($sformatf("v%0d.instr_req", i),  {31'd0, instr_req},   {31'd0, vq[i].e_ireq});
            chk($sformatf("v%0d.instr_addr", i), instr_addr,           vq[i].e_addr);
            chk($sformatf("v%0d.data_req", i),   {31'd0, data_req},    {31'd0, vq[i].e_dreq});
            chk($sformatf("v%0d.rf_we", i),      {31'd0, rf_write_en}, {31'd0, vq[i].e_rf});
            chk($sformatf("v%0d.trap", i),       {31'd0, trap},        {31'd0, vq[i].e_trap});
            chk($sformatf("v%0d.cause", i),      {30'd0, trap_cause},  {30'd0, vq[i].e_cause});
        end
        chk("trap.ir_frozen", ir, I_BEQ);

        // ---- reset pulse during a MEM wait ---------------------------------
        do_reset();
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);   // -> FETCH
        cyc(1'b1, 1'b0, I_LW,  1'b0, 1'b0, 1'b0, 32'h0);   // -> DECODE
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);   // -> EXECUTE
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);   // -> MEM
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);   // MEM wait
        chk("mrst.dreq_before", {31'd0, data_req}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("mrst.dreq_async",  {31'd0, data_req},  32'd0);
        chk("mrst.ireq_async",  {31'd0, instr_req}, 32'd0);
        chk("mrst.pc_async",    pc,                 32'h0000_0100);
        chk("mrst.ir_async",    ir,                 32'h0000_0013);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("mrst.refetch_req",  {31'd0, instr_req}, 32'd1);
        chk("mrst.refetch_addr", instr_addr,         32'h0000_0100);
        chk("mrst.trap",         {31'd0, trap},      32'd0);

        // ---- fetch timeout: 4 silent request cycles ------------------------
        do_reset();
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);   // -> FETCH
        for (int k = 1; k <= 3; k++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
            chk($sformatf("tmo.wait%0d.ireq", k), {31'd0, instr_req}, 32'd1);
            chk($sformatf("tmo.wait%0d.addr", k), instr_addr,         32'h0000_0100);
            chk($sformatf("tmo.wait%0d.trap", k), {31'd0, trap},      32'd0);
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("tmo.trap",  {31'd0, trap},       32'd1);
        chk("tmo.cause", {30'd0, trap_cause}, 32'd2);
        chk("tmo.ireq",  {31'd0, instr_req},  32'd0);

        // ---- fetch ack in the 4th request cycle wins over timeout ----------
        do_reset();
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, I_ADDI, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("tmoack.trap", {31'd0, trap}, 32'd0);
        chk("tmoack.ir",   ir,            I_ADDI);

        // ---- compressed instruction -> illegal -----------------------------
        do_reset();
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, I_CMP, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("cmp.trap",  {31'd0, trap},       32'd1);
        chk("cmp.cause", {30'd0, trap_cause}, 32'd3);
        chk("cmp.pc",    pc,                  32'h0000_0100);

        // ---- instr_err together with instr_ack -> bus error ----------------
        do_reset();
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, I_ADDI, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("ierr.trap",  {31'd0, trap},       32'd1);
        chk("ierr.cause", {30'd0, trap_cause}, 32'd1);
        chk("ierr.ir",    ir,                  32'h0000_0013);

        // ---- data_err in MEM -> bus error ----------------------------------
        do_reset();
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, I_SW,  1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("derr.trap",  {31'd0, trap},       32'd1);
        chk("derr.cause", {30'd0, trap_cause}, 32'd1);
        chk("derr.dreq",  {31'd0, data_req},   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
